// File: rtl/pit_irq_sink_if.sv
// pit_irq_sink_if: timer/host-side signal bundle for pit_irq_sink.
// The master modport is the environment (timer + host); the slave modport is the sink.
interface pit_irq_sink_if #(
  parameter int unsigned CNT_W = 8
) ();

  // environment -> sink
  logic             i_enable;
  logic             i_irq_in;
  logic             i_ack;
  logic             i_clear_overrun;

  // sink -> environment
  logic             o_irq_out;
  logic [CNT_W-1:0] o_pending_count;
  logic             o_overrun;
  logic             o_serviced;
  logic             o_timeout;

  modport master (
    output i_enable,
    output i_irq_in,
    output i_ack,
    output i_clear_overrun,
    input  o_irq_out,
    input  o_pending_count,
    input  o_overrun,
    input  o_serviced,
    input  o_timeout
  );

  modport slave (
    input  i_enable,
    input  i_irq_in,
    input  i_ack,
    input  i_clear_overrun,
    output o_irq_out,
    output o_pending_count,
    output o_overrun,
    output o_serviced,
    output o_timeout
  );

endinterface

// File: rtl/pit_irq_sink.sv
// pit_irq_sink: turns the interval timer's one-cycle interrupt pulses into a
// level interrupt with a host acknowledge handshake. Events arriving before
// the acknowledge are queued in a saturating pending counter; an event that
// finds the counter saturated sets a sticky overrun flag.
// Optional feature macro: IRQ_TIMEOUT_EN adds an acknowledge-timeout pulse
// generator; without it o_timeout is tied low and TIMEOUT only gets range-checked.
module pit_irq_sink #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pit_irq_sink_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Reject parameter values the counters cannot represent.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pit_irq_sink: CNT_W must be >= 1");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("pit_irq_sink: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_GAP     = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_irq_in_q;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_overrun;
  logic             w_overrun_next;
  logic             r_irq_out;
  logic             r_serviced;
  logic             w_event;
  logic             w_acc_ack;
  logic             w_ovf;

  // Rising edge of the timer line while accepting; a held-high line is one event.
  assign w_event = bus.i_enable & bus.i_irq_in & ~r_irq_in_q;

  // Next-state, pending-count and overrun logic.
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_overrun_next = r_overrun;
    w_acc_ack      = 1'b0;
    w_ovf          = 1'b0;

    if (r_state == ST_PENDING) begin
      w_acc_ack = bus.i_ack;
    end

    // An event and an accepted ack in the same cycle cancel out.
    if (w_event && !w_acc_ack) begin
      if (r_count == CNT_MAX) begin
        w_ovf = 1'b1;
      end else begin
        w_count_next = r_count + CNT_W'(1);
      end
    end else if (w_acc_ack && !w_event) begin
      w_count_next = r_count - CNT_W'(1);
    end

    // A new overrun wins over a same-cycle clear.
    if (w_ovf) begin
      w_overrun_next = 1'b1;
    end else if (bus.i_clear_overrun) begin
      w_overrun_next = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_event) begin
          w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_acc_ack) begin
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        // One low cycle so the host sees a fresh edge for the next event.
        w_state_next = (w_count_next != '0) ? ST_PENDING : ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_irq_in_q <= 1'b0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_irq_out  <= 1'b0;
      r_serviced <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_irq_in_q <= bus.i_irq_in;
      r_count    <= w_count_next;
      r_overrun  <= w_overrun_next;
      r_irq_out  <= (w_state_next == ST_PENDING);
      r_serviced <= w_acc_ack;
    end
  end

  assign bus.o_irq_out       = r_irq_out;
  assign bus.o_pending_count = r_count;
  assign bus.o_overrun       = r_overrun;
  assign bus.o_serviced      = r_serviced;

`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned    TO_W    = 16;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_next;
  logic            r_timeout;
  logic            w_timeout_next;

  // Count un-acked PENDING cycles; anything else (IDLE, GAP, ack) clears it.
  always_comb begin
    w_to_cnt_next  = '0;
    w_timeout_next = 1'b0;
    if ((r_state == ST_PENDING) && !bus.i_ack) begin
      if (r_to_cnt == TO_LAST) begin
        w_timeout_next = 1'b1;
      end else begin
        w_to_cnt_next = r_to_cnt + TO_W'(1);
      end
    end
  end

  // Timeout counter and registered pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_to_cnt  <= w_to_cnt_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign bus.o_timeout = r_timeout;
`else
  assign bus.o_timeout = 1'b0;
`endif

`ifndef SYNTHESIS
  // A serviced pulse always coincides with the GAP low cycle.
  a_serviced_in_gap : assert property (@(posedge i_clk) disable iff (i_rst)
    r_serviced |-> !r_irq_out);

  // The count never reaches zero while the interrupt is raised.
  a_count_nonzero_when_irq : assert property (@(posedge i_clk) disable iff (i_rst)
    r_irq_out |-> (r_count != '0));
`endif

endmodule

// File: doc/pit_irq_sink.md
Name: pit_irq_sink

Overview:
- Consumer end of the interval timer's interrupt line: accepts the timer's single-cycle interrupt pulses and turns them into a level interrupt for a host.
- Host acknowledge handshake; one acknowledge retires one event.
- Queues events that arrive before acknowledge in a saturating pending counter and flags overrun.
- Sits between the timer and the host/JTAG status logic.

Parameters:
CNT_W, 8, width of pending-event counter; saturates at 2^CNT_W-1
TIMEOUT, 1000, cycles in PENDING without ack before timeout fires (used only with IRQ_TIMEOUT_EN); must be >=1 and < 2^16

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = accept new events; 0 = ignore irq_in (already-pending events retained)
irq_in  input  1  interrupt from timer, nominally one-cycle pulses
ack  input  1  host acknowledge, sampled each cycle; meaningful only in PENDING
clear_overrun  input  1  clears sticky overrun
irq_out  output  1  level interrupt to host
pending_count  output  CNT_W  events not yet acknowledged
overrun  output  1  sticky: event arrived while counter saturated
serviced  output  1  one-cycle pulse per accepted ack
timeout  output  1  one-cycle pulse on ack timeout (0 without macro)

Behaviour:
- Reset (async, active-high): state=IDLE. irq_out=0, pending_count=0, overrun=0, serviced=0, timeout=0, irq_in_q=0, timeout counter=0. Reset mid-operation discards all pending events.
- Event detect: event = enable & irq_in & ~irq_in_q, where irq_in_q is irq_in registered. A held-high irq_in is one event. irq_in_q updates regardless of enable.
- Count update per cycle: pending_count_next = pending_count + event - accepted_ack.
  - Increment at saturation (2^CNT_W-1) with no simultaneous accepted_ack: count holds and overrun sets.
  - Event and accepted_ack in the same cycle: count unchanged, overrun not set.
- Overrun: set has priority over a same-cycle clear_overrun.
- States:
  - IDLE: irq_out=0. On event: next state PENDING, count=1. irq_out rises the cycle after the event (1-cycle latency).
  - PENDING: irq_out=1. accepted_ack = ack. On ack: serviced pulses next cycle, count decrements per the rule above, next state GAP.
  - GAP: irq_out=0 for exactly one cycle so the host sees a fresh edge. ack ignored. Events still counted. Next state is PENDING if pending_count != 0 after this cycle's update, else IDLE.
- ack in IDLE or GAP: ignored; no serviced pulse, no count change.
- enable deasserted in PENDING: state, irq_out and count unchanged; host may still ack.
- Outputs irq_out, serviced, timeout are registered.

Optional Feature:
- Macro IRQ_TIMEOUT_EN.
- Defined: 16-bit timeout counter, cleared on entry to PENDING, increments each PENDING cycle without ack. On reaching TIMEOUT: timeout pulses one cycle (registered), counter restarts at 0, state stays PENDING. Counter cleared in IDLE/GAP and on ack.
- Not defined: no counter logic; timeout tied 0; TIMEOUT unused.

Test Plan:
- Reset, enable=1, one-cycle irq_in at cycle 5 -> irq_out=1 from cycle 6, pending_count=1. ack at cycle 10 -> serviced=1 at cycle 11, irq_out=0 at 11, state IDLE, count=0.
- Three irq_in pulses 2 cycles apart before ack -> count=3. Three acks, each after GAP -> irq_out deasserts one cycle between each; count 2,1,0; serviced pulses 3 times; final IDLE.
- CNT_W=2, five pulses without ack -> count saturates at 3, overrun=1. clear_overrun pulse -> overrun=0, count stays 3.
- irq_in held high 20 cycles -> exactly one event, count=1. irq_in pulse with enable=0 -> ignored, count unchanged.
- Event on same cycle as ack in PENDING with count=1 -> count stays 1, GAP one cycle, back to PENDING with irq_out=1. Assert reset during PENDING -> irq_out=0 and count=0 immediately, without waiting for a clock edge.
- With IRQ_TIMEOUT_EN and TIMEOUT=8, event with no ack -> timeout pulses every 8 PENDING cycles while irq_out stays 1. Without the macro -> timeout stays 0 throughout.
